// File: rtl/ram_pkg.sv
// Shared constants and byte helpers for the simple-dual-port RAM.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   RDW_OLD / RDW_NEW : read-during-write mode selectors
//   byte_parity       : even-parity bit of one byte
//   be_merge          : per-byte select between stored and incoming data
package ram_pkg;

  localparam int RDW_OLD = 0;  // same-address read returns the pre-write word
  localparam int RDW_NEW = 1;  // same-address read returns write-first merged word

  // Even parity: the returned bit makes byte+parity carry an even number of ones.
  function automatic logic byte_parity(input logic [7:0] data_byte);
    return ^data_byte;
  endfunction

  // Selects the incoming byte when its enable is set, otherwise keeps the old one.
  function automatic logic [7:0] be_merge(input logic [7:0] old_byte,
                                          input logic [7:0] new_byte,
                                          input logic       be);
    return be ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/ram_out_stage.sv
// One read-pipeline register: valid flag, data word and (optionally) parity-error flags.
// Latency: 1 cycle from load_* to valid/data.
// Backpressure: ce low freezes the whole stage, including valid; no ready signal.
//
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset (clears valid, data, perr)
//   ce                  : stage enable; low holds every register
//   load_valid/load_data: value presented to the stage
//   load_perr/perr      : per-byte parity-error flags, present only with RAM_SDP_PARITY_EN
//   valid/data          : registered outputs; data and perr hold when a bubble passes
module ram_out_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
`ifdef RAM_SDP_PARITY_EN
  input  logic [DATA_W/8-1:0] load_perr,
  output logic [DATA_W/8-1:0] perr,
`endif
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
`ifdef RAM_SDP_PARITY_EN
      perr  <= '0;
`endif
    end else if (ce) begin
      valid <= load_valid;
      // Payload only moves with a real result so the output keeps the last read.
      if (load_valid) begin
        data <= load_data;
`ifdef RAM_SDP_PARITY_EN
        perr <= load_perr;
`endif
      end
    end
  end

endmodule

// File: rtl/ram_sdp_be.sv
// Simple-dual-port RAM with byte enables, selectable read-during-write and optional output register.
// Latency: read result 1 cycle after request (OUT_REG=0) or 2 cycles (OUT_REG=1).
// Backpressure: none; ce low stalls writes, read launch and the whole read pipeline.
//
// Optional feature macro: RAM_SDP_PARITY_EN (per-byte even parity, par_inj / par_err ports).
//
// Ports:
//   clk, rst_n         : clock, synchronous active-low reset (memory array is not cleared)
//   ce                 : global enable
//   wr_en/wr_addr/wr_data/wr_be : write port, wr_be bit i covers wr_data[8i+7:8i]
//   par_inj            : (parity build) invert stored parity of bytes written this cycle
//   par_err            : (parity build) per-byte parity mismatch, aligned with rd_data
//   rd_en/rd_addr      : read request
//   rd_data/rd_valid   : read result; rd_data holds its last value between results
module ram_sdp_be
  import ram_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 8,
  parameter int OUT_REG  = 0,
  parameter int RDW_MODE = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ce,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
`ifdef RAM_SDP_PARITY_EN
  input  logic                par_inj,
  output logic [DATA_W/8-1:0] par_err,
`endif
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  if (DATA_W % 8 != 0) begin : g_bad_width
    $error("ram_sdp_be: DATA_W must be a multiple of 8");
  end
  if (RDW_MODE != RDW_OLD && RDW_MODE != RDW_NEW) begin : g_bad_rdw
    $error("ram_sdp_be: RDW_MODE must be RDW_OLD or RDW_NEW");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_fire;
  logic              bypass;
  logic [DATA_W-1:0] rd_word;

  // Writes seen while reset is held are dropped, not merely delayed.
  assign wr_fire = rst_n & ce & wr_en;

  // Write-first forwarding only applies to a same-address write that really lands.
  assign bypass = (RDW_MODE == RDW_NEW) && wr_fire && (wr_addr == rd_addr);

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_word = mem[rd_addr];
    for (int i = 0; i < NB; i++) begin
      rd_word[8*i +: 8] = be_merge(mem[rd_addr][8*i +: 8], wr_data[8*i +: 8],
                                   bypass & wr_be[i]);
    end
  end

`ifdef RAM_SDP_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] rd_perr;
  logic [NB-1:0] s1_perr;

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) par_mem[wr_addr][i] <= byte_parity(wr_data[8*i +: 8]) ^ par_inj;
      end
    end
  end

  // Forwarded bytes come straight off the write bus, so their parity is fresh by construction.
  always_comb begin
    rd_perr = '0;
    for (int i = 0; i < NB; i++) begin
      if (!(bypass && wr_be[i])) begin
        rd_perr[i] = par_mem[rd_addr][i] ^ byte_parity(mem[rd_addr][8*i +: 8]);
      end
    end
  end
`endif

  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;

  ram_out_stage #(.DATA_W(DATA_W)) u_stage1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .ce         (ce),
    .load_valid (rd_en),
    .load_data  (rd_word),
`ifdef RAM_SDP_PARITY_EN
    .load_perr  (rd_perr),
    .perr       (s1_perr),
`endif
    .valid      (s1_valid),
    .data       (s1_data)
  );

  if (OUT_REG != 0) begin : g_out_reg
    ram_out_stage #(.DATA_W(DATA_W)) u_stage2 (
      .clk        (clk),
      .rst_n      (rst_n),
      .ce         (ce),
      .load_valid (s1_valid),
      .load_data  (s1_data),
`ifdef RAM_SDP_PARITY_EN
      .load_perr  (s1_perr),
      .perr       (par_err),
`endif
      .valid      (rd_valid),
      .data       (rd_data)
    );
  end else begin : g_no_out_reg
    assign rd_valid = s1_valid;
    assign rd_data  = s1_data;
`ifdef RAM_SDP_PARITY_EN
    assign par_err  = s1_perr;
`endif
  end

endmodule

// File: tb/tb_ram_sdp_be.sv
// Directed self-checking bench for ram_sdp_be.
// Three instances share one stimulus stream: d0 (OUT_REG=0, old-data RDW),
// d1 (OUT_REG=0, write-first RDW), d2 (OUT_REG=1, old-data RDW).
module tb_ram_sdp_be;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        rd_en;
  logic [7:0]  rd_addr;

  logic [31:0] d0_data, d1_data, d2_data;
  logic        d0_valid, d1_valid, d2_valid;
`ifdef RAM_SDP_PARITY_EN
  logic        par_inj;
  logic [3:0]  d0_perr, d1_perr, d2_perr;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ram_sdp_be #(.DATA_W(32), .ADDR_W(8), .OUT_REG(0), .RDW_MODE(0)) d0 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be),
`ifdef RAM_SDP_PARITY_EN
    .par_inj(par_inj), .par_err(d0_perr),
`endif
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(d0_data), .rd_valid(d0_valid));

  ram_sdp_be #(.DATA_W(32), .ADDR_W(8), .OUT_REG(0), .RDW_MODE(1)) d1 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be),
`ifdef RAM_SDP_PARITY_EN
    .par_inj(par_inj), .par_err(d1_perr),
`endif
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(d1_data), .rd_valid(d1_valid));

  ram_sdp_be #(.DATA_W(32), .ADDR_W(8), .OUT_REG(1), .RDW_MODE(0)) d2 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be),
`ifdef RAM_SDP_PARITY_EN
    .par_inj(par_inj), .par_err(d2_perr),
`endif
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(d2_data), .rd_valid(d2_valid));

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; wr_be = 4'h0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be; rd_en = 1'b0;
    tick();
    idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ce = 1'b1; idle();
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    tick(); tick();
    tests_run++;
    if ({d0_valid, d1_valid, d2_valid} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_valid: got %b expected 000", {d0_valid, d1_valid, d2_valid});
    end
    tests_run++;
    if (d0_data !== 32'h0 || d2_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_data: got d0=%h d2=%h expected 0", d0_data, d2_data);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    do_write(8'h10, 32'hDEADBEEF, 4'hF);
    rd_en = 1'b1; rd_addr = 8'h10;
    tick();
    rd_en = 1'b0;
    tests_run++;
    if (d0_valid !== 1'b1 || d0_data !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL rd_lat1: got valid=%b data=%h expected 1 deadbeef", d0_valid, d0_data);
    end
    tests_run++;
    if (d2_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rd_lat2_early: got valid=%b expected 0", d2_valid);
    end
    tick();
    tests_run++;
    if (d0_valid !== 1'b0 || d0_data !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL rd_hold: got valid=%b data=%h expected 0 deadbeef", d0_valid, d0_data);
    end
    tests_run++;
    if (d2_valid !== 1'b1 || d2_data !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL rd_lat2: got valid=%b data=%h expected 1 deadbeef", d2_valid, d2_data);
    end
    tick();
    tests_run++;
    if (d2_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rd_lat2_single: got valid=%b expected 0", d2_valid);
    end
  endtask

  task automatic test_byte_enable();
    do_write(8'h10, 32'h11223344, 4'b0101);
    rd_en = 1'b1; rd_addr = 8'h10;
    tick();
    rd_en = 1'b0;
    tests_run++;
    if (d0_data !== 32'hDE22BE44) begin
      tests_failed++;
      $display("FAIL byte_en: got %h expected de22be44", d0_data);
    end
    // A write with no byte enabled must leave the word untouched.
    do_write(8'h10, 32'hFFFFFFFF, 4'h0);
    rd_en = 1'b1; rd_addr = 8'h10;
    tick();
    rd_en = 1'b0;
    tests_run++;
    if (d0_data !== 32'hDE22BE44) begin
      tests_failed++;
      $display("FAIL byte_en_zero: got %h expected de22be44", d0_data);
    end
  endtask

  task automatic test_rdw();
    do_write(8'h20, 32'hAAAAAAAA, 4'hF);
    wr_en = 1'b1; wr_addr = 8'h20; wr_data = 32'h55555555; wr_be = 4'b0011;
    rd_en = 1'b1; rd_addr = 8'h20;
    tick();
    idle();
    tests_run++;
    if (d0_data !== 32'hAAAAAAAA) begin
      tests_failed++;
      $display("FAIL rdw_old: got %h expected aaaaaaaa", d0_data);
    end
    tests_run++;
    if (d1_data !== 32'hAAAA5555) begin
      tests_failed++;
      $display("FAIL rdw_new: got %h expected aaaa5555", d1_data);
    end
    // Different addresses in the same cycle do not interact.
    wr_en = 1'b1; wr_addr = 8'h21; wr_data = 32'h12345678; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 8'h20;
    tick();
    idle();
    tests_run++;
    if (d0_data !== 32'hAAAA5555 || d1_data !== 32'hAAAA5555) begin
      tests_failed++;
      $display("FAIL rdw_diff_addr: got d0=%h d1=%h expected aaaa5555", d0_data, d1_data);
    end
  endtask

  task automatic test_back_to_back();
    do_write(8'h01, 32'h10000001, 4'hF);
    do_write(8'h02, 32'h20000002, 4'hF);
    do_write(8'h03, 32'h30000003, 4'hF);
    rd_en = 1'b1; rd_addr = 8'h01; tick();
    rd_addr = 8'h02; tick();
    tests_run++;
    if (d2_valid !== 1'b1 || d2_data !== 32'h10000001) begin
      tests_failed++;
      $display("FAIL b2b_r1: got valid=%b data=%h expected 1 10000001", d2_valid, d2_data);
    end
    rd_addr = 8'h03; tick();
    rd_en = 1'b0;
    tests_run++;
    if (d2_valid !== 1'b1 || d2_data !== 32'h20000002) begin
      tests_failed++;
      $display("FAIL b2b_r2: got valid=%b data=%h expected 1 20000002", d2_valid, d2_data);
    end
    tick();
    tests_run++;
    if (d2_valid !== 1'b1 || d2_data !== 32'h30000003) begin
      tests_failed++;
      $display("FAIL b2b_r3: got valid=%b data=%h expected 1 30000003", d2_valid, d2_data);
    end
    tick();
    tests_run++;
    if (d2_valid !== 1'b0 || d2_data !== 32'h30000003) begin
      tests_failed++;
      $display("FAIL b2b_end: got valid=%b data=%h expected 0 30000003", d2_valid, d2_data);
    end
  endtask

  task automatic test_ce_stall();
    rd_en = 1'b1; rd_addr = 8'h01; tick();
    rd_addr = 8'h02; tick();
    rd_addr = 8'h03; tick();
    // Pipeline now: d2 shows result 2, result 3 waits in the first stage.
    rd_en = 1'b0; ce = 1'b0;
    // This write must be blocked by ce.
    wr_en = 1'b1; wr_addr = 8'h01; wr_data = 32'h0BAD0BAD; wr_be = 4'hF;
    for (int k = 0; k < 2; k++) begin
      tick();
      tests_run++;
      if (d2_valid !== 1'b1 || d2_data !== 32'h20000002) begin
        tests_failed++;
        $display("FAIL ce_hold_d2 cyc%0d: got valid=%b data=%h expected 1 20000002", k, d2_valid, d2_data);
      end
      tests_run++;
      if (d0_valid !== 1'b1 || d0_data !== 32'h30000003) begin
        tests_failed++;
        $display("FAIL ce_hold_d0 cyc%0d: got valid=%b data=%h expected 1 30000003", k, d0_valid, d0_data);
      end
    end
    idle(); ce = 1'b1;
    tick();
    tests_run++;
    if (d2_valid !== 1'b1 || d2_data !== 32'h30000003) begin
      tests_failed++;
      $display("FAIL ce_resume_d2: got valid=%b data=%h expected 1 30000003", d2_valid, d2_data);
    end
    tests_run++;
    if (d0_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL ce_resume_d0: got valid=%b expected 0", d0_valid);
    end
    tick();
    tests_run++;
    if (d2_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL ce_no_dup: got valid=%b expected 0", d2_valid);
    end
    rd_en = 1'b1; rd_addr = 8'h01; tick();
    rd_en = 1'b0;
    tests_run++;
    if (d0_data !== 32'h10000001) begin
      tests_failed++;
      $display("FAIL ce_write_blocked: got %h expected 10000001", d0_data);
    end
  endtask

  task automatic test_reset_mid();
    do_write(8'h40, 32'hCAFEF00D, 4'hF);
    rd_en = 1'b1; rd_addr = 8'h40; tick();
    // Reset with a write presented: the write must be ignored.
    rd_en = 1'b0; rst_n = 1'b0;
    wr_en = 1'b1; wr_addr = 8'h40; wr_data = 32'h0; wr_be = 4'hF;
    tick();
    idle();
    tests_run++;
    if ({d0_valid, d2_valid} !== 2'b00 || d0_data !== 32'h0 || d2_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL rst_mid: got v=%b d0=%h d2=%h expected 00 0 0", {d0_valid, d2_valid}, d0_data, d2_data);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      tests_run++;
      if (d2_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL rst_late_valid cyc%0d: got %b expected 0", k, d2_valid);
      end
    end
    rd_en = 1'b1; rd_addr = 8'h40; tick();
    rd_en = 1'b0;
    tests_run++;
    if (d0_data !== 32'hCAFEF00D) begin
      tests_failed++;
      $display("FAIL rst_mem_kept: got %h expected cafef00d", d0_data);
    end
    tick();
    tests_run++;
    if (d2_valid !== 1'b1 || d2_data !== 32'hCAFEF00D) begin
      tests_failed++;
      $display("FAIL rst_mem_kept_d2: got valid=%b data=%h expected 1 cafef00d", d2_valid, d2_data);
    end
  endtask

`ifdef RAM_SDP_PARITY_EN
  task automatic test_parity();
    par_inj = 1'b0;
    do_write(8'h50, 32'h0, 4'hF);
    par_inj = 1'b1;
    do_write(8'h50, 32'h000000FF, 4'h1);
    par_inj = 1'b0;
    rd_en = 1'b1; rd_addr = 8'h50; tick();
    rd_en = 1'b0;
    tests_run++;
    if (d0_valid !== 1'b1 || d0_perr !== 4'b0001 || d0_data !== 32'h000000FF) begin
      tests_failed++;
      $display("FAIL par_inj: got valid=%b perr=%b data=%h expected 1 0001 000000ff", d0_valid, d0_perr, d0_data);
    end
    tick();
    tests_run++;
    if (d2_perr !== 4'b0001) begin
      tests_failed++;
      $display("FAIL par_inj_d2: got %b expected 0001", d2_perr);
    end
    do_write(8'h50, 32'h000000FF, 4'h1);
    rd_en = 1'b1; rd_addr = 8'h50; tick();
    rd_en = 1'b0;
    tests_run++;
    if (d0_perr !== 4'b0000) begin
      tests_failed++;
      $display("FAIL par_clean: got %b expected 0000", d0_perr);
    end
    // Same-address injected write: forwarded byte carries fresh parity.
    par_inj = 1'b1;
    wr_en = 1'b1; wr_addr = 8'h50; wr_data = 32'h000000FF; wr_be = 4'h1;
    rd_en = 1'b1; rd_addr = 8'h50;
    tick();
    idle(); par_inj = 1'b0;
    tests_run++;
    if (d1_perr !== 4'b0000 || d0_perr !== 4'b0000) begin
      tests_failed++;
      $display("FAIL par_bypass: got d1=%b d0=%b expected 0000", d1_perr, d0_perr);
    end
    rd_en = 1'b1; rd_addr = 8'h50; tick();
    rd_en = 1'b0;
    tests_run++;
    if (d0_perr !== 4'b0001) begin
      tests_failed++;
      $display("FAIL par_stored: got %b expected 0001", d0_perr);
    end
  endtask
`endif

  initial begin
`ifdef RAM_SDP_PARITY_EN
    par_inj = 1'b0;
`endif
    rst_n = 1'b0; ce = 1'b1; idle();
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    test_reset();
    test_write_read();
    test_byte_enable();
    test_rdw();
    test_back_to_back();
    test_ce_stall();
    test_reset_mid();
`ifdef RAM_SDP_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ram_sdp_be.md
Name: ram_sdp_be

Overview:
- Parametrised simple-dual-port RAM: one write port, one read port, one clock.
- Successor to the 8x256 single-port RAM. Adds:
  - generic width and depth,
  - per-byte write enables,
  - concurrent read and write,
  - selectable read-during-write (RDW) behaviour,
  - optional output register,
  - read-valid tracking.
- Used as the general storage primitive for buffers and register files across the design.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8 (elaboration-time error otherwise).
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words.
- OUT_REG, 0, 0 = read latency 1 cycle; 1 = extra output register, latency 2 cycles.
- RDW_MODE, 0, same-address read during write: 0 = old data, 1 = new (write-first, byte-merged) data.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- ce  in  1  global enable; low = no write, no read launch, pipeline holds.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_be  in  DATA_W/8  byte enables; bit i covers wr_data[8i+7:8i].
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  read data.
- rd_valid  out  1  rd_data carries the result of a read request this cycle.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset (rst_n low at a posedge):
  - rd_valid = 0, rd_data = 0, all pipeline valid/data stages = 0.
  - Memory array is NOT cleared.
  - Reads in flight when reset asserts are dropped; no rd_valid for them.
  - Writes presented while rst_n is low are ignored.
- Write: at posedge with ce & wr_en, for each i with wr_be[i]=1, mem[wr_addr] byte i <= wr_data byte i. Unselected bytes are unchanged; wr_be = 0 is a no-op.
- Read launch: at posedge with ce & rd_en, capture mem[rd_addr] into stage 1.
- Latency:
  - OUT_REG=0: rd_data/rd_valid update at the first posedge after launch (visible the cycle after request).
  - OUT_REG=1: visible two cycles after request.
  - Back-to-back reads give one result per cycle.
- rd_valid: high for exactly one cycle per accepted read.
- rd_data hold: keeps its last value when rd_valid = 0; it is not zeroed between reads.
- ce = 0: all stages (including rd_valid) hold. A result pending in the output register stays valid until ce returns and it advances.
  - OUT_REG=0: rd_valid stays high while ce is low.
- Read-during-write, same cycle, rd_addr == wr_addr:
  - RDW_MODE=0: returns pre-write word.
  - RDW_MODE=1: bytes with wr_be=1 come from wr_data; the rest from memory.
  - Different addresses: fully independent.
- Read of a never-written address returns X in simulation; benches must not check it.

Optional Feature:
- Macro: RAM_SDP_PARITY_EN.
- With the macro defined:
  - Memory stores one even-parity bit per byte, computed from the byte value written. Unwritten bytes keep their stored parity.
  - Extra port par_inj (in, 1): when high during a write, stored parity of all written bytes is inverted (error injection).
  - Extra port par_err (out, DATA_W/8): per-byte mismatch on the read word. Pipelined and held exactly like rd_data; reset value 0.
  - Meaningful only when rd_valid = 1.
  - RDW_MODE=1 bypassed bytes use freshly computed parity (no error), even if par_inj is high.
- Without the macro: no parity storage; ports par_inj and par_err do not exist.

Decomposition:
- Package ram_pkg:
  - constants RDW_OLD=0, RDW_NEW=1;
  - function byte_parity(byte) (XOR reduce);
  - function be_merge(old, new, be).
- One sub-module, ram_out_stage: valid/data (+par_err) register with ce hold and sync reset. Instanced once (OUT_REG=0) or twice (OUT_REG=1).

Test Plan:
- DATA_W=32, OUT_REG=0: write 0xDEADBEEF at addr 0x10, be=4'hF; read 0x10 next cycle -> rd_valid=1 one cycle later, rd_data=0xDEADBEEF.
- Byte enables: after the above, write 0x11223344 at 0x10, be=4'b0101; read -> 0xDE22BE44.
- RDW: mem[0x20]=0xAAAAAAAA; same cycle write 0x55555555 be=4'b0011 and read 0x20 -> RDW_MODE=0: 0xAAAAAAAA; RDW_MODE=1: 0xAAAA5555.
- OUT_REG=1: reads to addrs 1,2,3 on consecutive cycles -> results 2 cycles after each request, rd_valid high for 3 consecutive cycles. Drop ce for 2 cycles mid-stream -> outputs hold, no data lost or duplicated.
- Reset mid-operation: issue read, assert rst_n=0 the next cycle -> rd_valid=0, rd_data=0, no late valid. Memory contents intact on a subsequent read.
- RAM_SDP_PARITY_EN: write 0x000000FF be=4'h1 with par_inj=1; read -> par_err=4'b0001 with rd_valid. Rewrite with par_inj=0 -> par_err=0.
